uart_frame_rx: RTL and testbench



---
 rtl/uart_frame_pkg.sv | 21 ++
 rtl/uart_frame_rx_byte.sv | 92 +++++++++
 rtl/uart_frame_rx.sv | 158 +++++++++++++++
 tb/tb_uart_frame_rx.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_frame_pkg.sv
// Shared constants and state encodings for the UART frame receiver.
// F_CSUM is only reachable when UART_FRAME_CHECKSUM_EN is defined.
package uart_frame_pkg;

  localparam logic [7:0] FRAME_HDR = 8'hA5;
  localparam int         FRAME_LEN = 8;

  typedef enum logic [1:0] {
    B_IDLE,
    B_START,
    B_DATA,
    B_STOP
  } b_state_t;

  typedef enum logic [1:0] {
    F_HDR,
    F_PAY,
    F_CSUM
  } f_state_t;

endpackage

// File: rtl/uart_frame_rx_byte.sv
// 8N1 byte receiver: two-flop RX synchroniser plus start/data/stop sampling FSM.
// Emits a one-cycle o_byte_vld or o_byte_ferr in the cycle after the stop sample.
module uart_byte_rx
  import uart_frame_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx,
  output logic [7:0] o_byte,
  output logic       o_byte_vld,
  output logic       o_byte_ferr,
  output logic       o_idle,
  output b_state_t   o_state
);

  localparam int             CW      = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]  HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0]  FULL_M1 = CW'(CLKS_PER_BIT - 1);

  logic          r_sync1;
  logic          r_sync2;
  b_state_t      r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          r_vld;
  logic          r_ferr;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_state <= B_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_vld   <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_sync1 <= i_rx;
      r_sync2 <= r_sync1;
      r_vld   <= 1'b0;
      r_ferr  <= 1'b0;
      case (r_state)
        B_IDLE: begin
          r_cnt <= '0;
          if (!r_sync2) r_state <= B_START;
        end
        B_START: begin
          // A start bit that is gone by mid-bit was a glitch.
          if (r_cnt == HALF_M1) begin
            r_cnt   <= '0;
            r_bit   <= '0;
            r_state <= r_sync2 ? B_IDLE : B_DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        B_DATA: begin
          if (r_cnt == FULL_M1) begin
            r_cnt   <= '0;
            r_shift <= {r_sync2, r_shift[7:1]};
            r_bit   <= r_bit + 1'b1;
            if (r_bit == 3'd7) r_state <= B_STOP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        B_STOP: begin
          if (r_cnt == FULL_M1) begin
            r_cnt   <= '0;
            r_vld   <= r_sync2;
            r_ferr  <= ~r_sync2;
            r_state <= B_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= B_IDLE;
      endcase
    end
  end

  assign o_byte      = r_shift;
  assign o_byte_vld  = r_vld;
  assign o_byte_ferr = r_ferr;
  assign o_idle      = (r_state == B_IDLE);
  assign o_state     = r_state;

endmodule

// File: rtl/uart_frame_rx.sv
// Frame parser: header 0xA5 + 8 payload bytes (+ checksum when UART_FRAME_CHECKSUM_EN
// is defined), committed atomically to DATA_IN0..7. CLK_HZ/BAUD must be at least 8.
module uart_frame_rx
  import uart_frame_pkg::*;
#(
  parameter int CLK_HZ       = 12000000,
  parameter int BAUD         = 115200,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RX,
  output logic [7:0] DATA_IN0,
  output logic [7:0] DATA_IN1,
  output logic [7:0] DATA_IN2,
  output logic [7:0] DATA_IN3,
  output logic [7:0] DATA_IN4,
  output logic [7:0] DATA_IN5,
  output logic [7:0] DATA_IN6,
  output logic [7:0] DATA_IN7,
  output logic       FRAME_STB,
  output logic       FRAME_ERR,
  output b_state_t   o_dbg_bstate,
  output f_state_t   o_dbg_fstate
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int TIMEOUT_CLKS = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TW           = $clog2(TIMEOUT_CLKS);

  logic [7:0] w_byte;
  logic       w_byte_vld;
  logic       w_byte_ferr;
  logic       w_idle;
  logic       w_counting;
  logic       w_tmo_exp;
  logic [7:0] w_pay [FRAME_LEN];

  f_state_t   r_fstate;
  logic [2:0] r_idx;
  logic [7:0] r_shadow [FRAME_LEN];
  logic [7:0] r_data [FRAME_LEN];
  logic       r_stb;
  logic       r_err;
  logic [TW-1:0] r_tmo;
`ifdef UART_FRAME_CHECKSUM_EN
  logic [7:0] r_sum;
`endif

  uart_byte_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte (
    .i_clk      (CLK),
    .i_rst      (RST),
    .i_rx       (RX),
    .o_byte     (w_byte),
    .o_byte_vld (w_byte_vld),
    .o_byte_ferr(w_byte_ferr),
    .o_idle     (w_idle),
    .o_state    (o_dbg_bstate)
  );

  // The timer only runs in the gaps between bytes of a frame in progress.
  assign w_counting = (r_fstate != F_HDR) && w_idle;
  assign w_tmo_exp  = w_counting && (r_tmo == TW'(TIMEOUT_CLKS - 1));

  // Shadow slots with the byte arriving this cycle merged in, so the last
  // payload byte can commit without an extra cycle.
  always_comb begin
    for (int i = 0; i < FRAME_LEN; i++) begin
      w_pay[i] = r_shadow[i];
      if (r_fstate == F_PAY && r_idx == 3'(i)) w_pay[i] = w_byte;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_fstate <= F_HDR;
      r_idx    <= '0;
      r_stb    <= 1'b0;
      r_err    <= 1'b0;
      r_tmo    <= '0;
`ifdef UART_FRAME_CHECKSUM_EN
      r_sum    <= '0;
`endif
      for (int i = 0; i < FRAME_LEN; i++) begin
        r_shadow[i] <= '0;
        r_data[i]   <= '0;
      end
    end else begin
      r_stb <= 1'b0;
      r_err <= 1'b0;
      if (w_byte_vld || r_fstate == F_HDR) r_tmo <= '0;
      else if (w_counting)                 r_tmo <= r_tmo + 1'b1;

      case (r_fstate)
        F_HDR: begin
          if (w_byte_vld && w_byte == FRAME_HDR) begin
            r_fstate <= F_PAY;
            r_idx    <= '0;
`ifdef UART_FRAME_CHECKSUM_EN
            r_sum    <= '0;
`endif
          end
        end
        F_PAY: begin
          if (w_byte_vld) begin
            r_shadow[r_idx] <= w_byte;
            r_idx           <= r_idx + 1'b1;
`ifdef UART_FRAME_CHECKSUM_EN
            r_sum           <= r_sum + w_byte;
            if (r_idx == 3'(FRAME_LEN - 1)) r_fstate <= F_CSUM;
`else
            if (r_idx == 3'(FRAME_LEN - 1)) begin
              for (int i = 0; i < FRAME_LEN; i++) r_data[i] <= w_pay[i];
              r_stb    <= 1'b1;
              r_fstate <= F_HDR;
            end
`endif
          end else if (w_byte_ferr || w_tmo_exp) begin
            r_err    <= 1'b1;
            r_fstate <= F_HDR;
          end
        end
`ifdef UART_FRAME_CHECKSUM_EN
        F_CSUM: begin
          if (w_byte_vld) begin
            if (8'(r_sum + w_byte) == 8'h00) begin
              for (int i = 0; i < FRAME_LEN; i++) r_data[i] <= w_pay[i];
              r_stb <= 1'b1;
            end else begin
              r_err <= 1'b1;
            end
            r_fstate <= F_HDR;
          end else if (w_byte_ferr || w_tmo_exp) begin
            r_err    <= 1'b1;
            r_fstate <= F_HDR;
          end
        end
`endif
        default: r_fstate <= F_HDR;
      endcase
    end
  end

  assign DATA_IN0     = r_data[0];
  assign DATA_IN1     = r_data[1];
  assign DATA_IN2     = r_data[2];
  assign DATA_IN3     = r_data[3];
  assign DATA_IN4     = r_data[4];
  assign DATA_IN5     = r_data[5];
  assign DATA_IN6     = r_data[6];
  assign DATA_IN7     = r_data[7];
  assign FRAME_STB    = r_stb;
  assign FRAME_ERR    = r_err;
  assign o_dbg_fstate = r_fstate;

endmodule

// File: tb/tb_uart_frame_rx.sv
// Bench for uart_frame_rx: serial byte driver, frame-level reference model and
// commit scoreboard. Build with +define+UART_FRAME_CHECKSUM_EN for checksummed frames.
module tb_uart_frame_rx;
  import uart_frame_pkg::*;

  localparam int CLK_HZ       = 12000000;
  localparam int BAUD         = 921600;
  localparam int TIMEOUT_BITS = 20;
  localparam int CPB          = CLK_HZ / BAUD;
`ifdef UART_FRAME_CHECKSUM_EN
  localparam int NB = FRAME_LEN + 1;
`else
  localparam int NB = FRAME_LEN;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx  = 1'b1;
  always #5 clk = ~clk;

  logic [7:0] d0, d1, d2, d3, d4, d5, d6, d7;
  logic       stb, err;
  b_state_t   dbg_b;
  f_state_t   dbg_f;
  wire [63:0] w_data = {d7, d6, d5, d4, d3, d2, d1, d0};

  uart_frame_rx #(
    .CLK_HZ(CLK_HZ), .BAUD(BAUD), .TIMEOUT_BITS(TIMEOUT_BITS)
  ) dut (
    .CLK(clk), .RST(rst), .RX(rx),
    .DATA_IN0(d0), .DATA_IN1(d1), .DATA_IN2(d2), .DATA_IN3(d3),
    .DATA_IN4(d4), .DATA_IN5(d5), .DATA_IN6(d6), .DATA_IN7(d7),
    .FRAME_STB(stb), .FRAME_ERR(err),
    .o_dbg_bstate(dbg_b), .o_dbg_fstate(dbg_f)
  );

  // ---------------- scoreboard state ----------------
  int          vec_n = 0;
  int          miss_n = 0;
  int          stb_n = 0;
  int          err_n = 0;
  int          exp_stb_n = 0;
  int          exp_err_n = 0;
  logic [63:0] exp_q[$];
  logic [63:0] exp_cur = '0;
  logic [63:0] prev_data = '0;
  logic [7:0]  stream[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vec_n++;
    assert (obs === expv) else begin
      miss_n++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Output monitor, sampled 1 time unit after the active edge.
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      if (stb) begin
        stb_n++;
        if (exp_q.size() == 0) check("spurious_stb", 64'(stb), 64'd0);
        else check("commit_data", w_data, exp_q.pop_front());
      end
      if (err) err_n++;
      if (stb || err) check("stb_err_excl", 64'(stb & err), 64'd0);
      if (w_data !== prev_data) check("data_change_needs_stb", 64'(stb), 64'd1);
    end
    prev_data = w_data;
  end

  // ---------------- reference model ----------------
  // Scans a clean byte stream: hunt for the header, take the next NB bytes as one frame.
  function automatic void model_stream();
    int i;
    i = 0;
    while (i < stream.size()) begin
      if (stream[i] != 8'hA5 || i + NB >= stream.size()) begin
        i++;
      end else begin
        logic [63:0] pay;
        logic [7:0]  sum;
        sum = 8'h00;
        for (int k = 0; k < FRAME_LEN; k++) begin
          pay[8*k +: 8] = stream[i+1+k];
          sum = sum + stream[i+1+k];
        end
`ifdef UART_FRAME_CHECKSUM_EN
        sum = sum + stream[i+1+FRAME_LEN];
`else
        sum = 8'h00;
`endif
        if (sum == 8'h00) begin
          exp_q.push_back(pay);
          exp_cur = pay;
          exp_stb_n++;
        end else begin
          exp_err_n++;
        end
        i += NB + 1;
      end
    end
  endfunction

  // ---------------- drivers ----------------
  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_stop);
    rx = 1'b0;
    idle_cycles(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      idle_cycles(CPB);
    end
    if (bad_stop) begin
      // Low across the stop sample, high again before a false start could complete.
      rx = 1'b0;
      idle_cycles(CPB / 2 + 3);
      rx = 1'b1;
      idle_cycles(CPB - CPB / 2 - 3);
    end else begin
      rx = 1'b1;
      idle_cycles(CPB);
    end
  endtask

  task automatic push_frame(input logic [63:0] pay, input logic [7:0] csum_delta);
    logic [7:0] sum;
    sum = 8'h00;
    stream.push_back(8'hA5);
    for (int k = 0; k < FRAME_LEN; k++) begin
      stream.push_back(pay[8*k +: 8]);
      sum = sum + pay[8*k +: 8];
    end
`ifdef UART_FRAME_CHECKSUM_EN
    stream.push_back(8'(8'h00 - sum) + csum_delta);
`else
    if (csum_delta != 8'h00) stream.push_back(8'h3C);
`endif
  endtask

  task automatic run_stream(input int gap_bits_max);
    model_stream();
    foreach (stream[i]) begin
      send_byte(stream[i], 1'b0);
      idle_cycles($urandom_range(0, gap_bits_max) * CPB);
    end
    stream.delete();
  endtask

  task automatic check_step(input string tag);
    idle_cycles(3 * CPB);
    check({tag, "_stb_count"}, 64'(stb_n), 64'(exp_stb_n));
    check({tag, "_err_count"}, 64'(err_n), 64'(exp_err_n));
    check({tag, "_data"}, w_data, exp_cur);
    check({tag, "_pending"}, 64'(exp_q.size()), 64'd0);
  endtask

  function automatic logic [63:0] rand_pay();
    return {$urandom(), $urandom()};
  endfunction

  // ---------------- directed sequence ----------------
  initial begin
    int err_before;
    @(negedge clk);
    rst = 1'b1;
    idle_cycles(5);
    rst = 1'b0;
    idle_cycles(1);
    check("reset_data", w_data, 64'd0);
    check("reset_stb", 64'(stb), 64'd0);
    check("reset_err", 64'(err), 64'd0);
    check("reset_bstate", 64'(dbg_b), 64'(B_IDLE));
    check("reset_fstate", 64'(dbg_f), 64'(F_HDR));
    idle_cycles(2000);
    check_step("quiet");

    push_frame(64'h0807060504030201, 8'h00);
    run_stream(0);
    check_step("basic");

    stream.push_back(8'h3C);
    stream.push_back(8'hFF);
    push_frame(64'h000000000000A5A5, 8'h00);
    run_stream(0);
    check_step("junk_and_a5");

    for (int f = 0; f < 3; f++) begin
      int nj;
      nj = $urandom_range(0, 2);
      for (int j = 0; j < nj; j++) begin
        logic [7:0] jb;
        jb = 8'($urandom_range(0, 255));
        stream.push_back(jb == 8'hA5 ? 8'h5A : jb);
      end
      push_frame(rand_pay(), 8'h00);
      run_stream(3);
      check_step("random_frame");
    end

    // Inter-byte gaps just under the timeout still commit.
    push_frame(rand_pay(), 8'h00);
    model_stream();
    foreach (stream[i]) begin
      send_byte(stream[i], 1'b0);
      idle_cycles((TIMEOUT_BITS - 3) * CPB);
    end
    stream.delete();
    check_step("long_gaps");

    err_before = exp_err_n;
    send_byte(8'hA5, 1'b0);
    for (int k = 0; k < 4; k++) send_byte(8'($urandom_range(0, 255)), 1'b0);
    idle_cycles(15 * CPB);
    check("timeout_not_early", 64'(err_n), 64'(err_before));
    idle_cycles(10 * CPB);
    exp_err_n++;
    check_step("timeout");
    push_frame(rand_pay(), 8'h00);
    run_stream(1);
    check_step("after_timeout");

    send_byte(8'hA5, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b1);
    exp_err_n++;
    check_step("stop_bit_error");
    push_frame(rand_pay(), 8'h00);
    run_stream(1);
    check_step("after_ferr");

`ifdef UART_FRAME_CHECKSUM_EN
    push_frame(rand_pay(), 8'h01);
    run_stream(0);
    check_step("bad_checksum");
`endif

    send_byte(8'hA5, 1'b0);
    for (int k = 0; k < 5; k++) send_byte(8'($urandom_range(0, 255)), 1'b0);
    rx = 1'b0;
    idle_cycles(3 * CPB);
    rx  = 1'b1;
    rst = 1'b1;
    idle_cycles(1);
    rst = 1'b0;
    exp_cur = '0;
    idle_cycles(30 * CPB);
    check_step("mid_frame_reset");
    check("post_reset_fstate", 64'(dbg_f), 64'(F_HDR));
    push_frame(rand_pay(), 8'h00);
    run_stream(2);
    check_step("after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vec_n, miss_n);
    $finish;
  end

endmodule
